// File: rtl/multicycle_control.sv
// multicycle_control -- sequencer for a multicycle MIPS-subset datapath.
//
// One ALU, one unified memory and one register file are time-shared across
// the states of each instruction. A Moore FSM walks the instruction phases
// and drives every mux select and write enable. The only Mealy outputs are
// ir_write and pc_write in FETCH, gated by mem_ready.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   op_code[5:0]   opcode field from the instruction register
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d         memory address: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   reg_dst        write register: 0 rt, 1 rd
//   mem_to_reg     write data: 0 ALUOut, 1 MDR
//   reg_write      register file write
//   alu_src_a      0 PC, 1 register A
//   alu_src_b[1:0] 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op[1:0]    00 add, 01 sub, 10 funct-decoded
//   state[3:0]     current state encoding (debug)
//   illegal_op     sticky unrecognised-opcode flag
//   instr_count    retired-instruction count, wraps silently
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   retire;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch
  // rather than in the sensitivity list; non-blocking assignments keep the
  // register update order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        // PC+4 is computed every cycle, but the IR and PC only load on the
        // cycle the memory actually returns the instruction.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        alu_src_b = 2'b11;
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_NOP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:      state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_code)
          OP_LW:   state_d = S_MEMREAD;
          OP_SW:   state_d = S_MEMWRITE;
          // Unreachable while the IR holds the opcode stable.
          default: state_d = S_ILLEGAL;
        endcase
      end

      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end

      S_MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      // Absorbing: only rst leaves, which also makes the flag sticky.
      S_ILLEGAL: illegal_op = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- directed, table-driven bench for multicycle_control.
// A 32-bit-counter instance and a 4-bit-counter instance share all inputs; the
// narrow one exercises counter wrap-around.
module tb_multicycle_control;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] NOP   = 6'b100000;
  localparam logic [5:0] BAD   = 6'b111111;

  // Control word: pc_write, pc_write_cond, pc_source[1:0], i_or_d, mem_read,
  // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
  // alu_src_b[1:0], alu_op[1:0], illegal_op
  localparam logic [16:0] C_IDLE     = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_FETCH_W  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
  localparam logic [16:0] C_FETCH_R  = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [16:0] C_DECODE   = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [16:0] C_MEMADDR  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [16:0] C_MEMREAD  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_MEMWB    = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [16:0] C_MEMWRITE = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_EXECUTE  = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [16:0] C_ALUWB    = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
  localparam logic [16:0] C_BRANCH   = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [16:0] C_JUMP     = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_ILLEGAL  = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_code;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4;
  logic        reg_dst4, mem_to_reg4, reg_write4, alu_src_a4, illegal_op4;
  logic [1:0]  pc_source4, alu_src_b4, alu_op4;
  logic [3:0]  state4;
  logic [3:0]  instr_count4;

  logic [16:0] ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .pc_source(pc_source4),
    .i_or_d(i_or_d4), .mem_read(mem_read4), .mem_write(mem_write4),
    .ir_write(ir_write4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
    .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_op(alu_op4), .state(state4), .illegal_op(illegal_op4),
    .instr_count(instr_count4)
  );

  assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                 mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_op, illegal_op};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares one cycle's outputs; the 4-bit instance must track the low
  // nibble of the 32-bit count.
  task automatic check_cycle(input string tag, input logic [3:0] st,
                             input logic [16:0] ctl, input logic [31:0] cnt);
    logic [3:0] cnt_lo;
    cnt_lo = cnt[3:0];
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(ctl));
    check({tag, ".count"}, instr_count, cnt);
    check({tag, ".count4"}, 32'(instr_count4), 32'(cnt_lo));
  endtask

  // Drives inputs at the falling edge and lets combinational outputs settle;
  // the following rising edge then commits the cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst       = r;
    op_code   = op;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    // LW with no wait (5 cycles)
    vecs[0]  = '{1'b0, LW,    1'b1, 4'd0,  C_IDLE,     32'd0};
    vecs[1]  = '{1'b0, LW,    1'b1, 4'd1,  C_FETCH_R,  32'd0};
    vecs[2]  = '{1'b0, LW,    1'b1, 4'd2,  C_DECODE,   32'd0};
    vecs[3]  = '{1'b0, LW,    1'b0, 4'd3,  C_MEMADDR,  32'd0};
    vecs[4]  = '{1'b0, LW,    1'b1, 4'd4,  C_MEMREAD,  32'd0};
    vecs[5]  = '{1'b0, LW,    1'b0, 4'd5,  C_MEMWB,    32'd0};
    // SW with three wait cycles in MEMWRITE
    vecs[6]  = '{1'b0, SW,    1'b1, 4'd1,  C_FETCH_R,  32'd1};
    vecs[7]  = '{1'b0, SW,    1'b1, 4'd2,  C_DECODE,   32'd1};
    vecs[8]  = '{1'b0, SW,    1'b1, 4'd3,  C_MEMADDR,  32'd1};
    vecs[9]  = '{1'b0, SW,    1'b0, 4'd6,  C_MEMWRITE, 32'd1};
    vecs[10] = '{1'b0, SW,    1'b0, 4'd6,  C_MEMWRITE, 32'd1};
    vecs[11] = '{1'b0, SW,    1'b0, 4'd6,  C_MEMWRITE, 32'd1};
    vecs[12] = '{1'b0, SW,    1'b1, 4'd6,  C_MEMWRITE, 32'd1};
    // RTYPE (4), BEQ (3), J (3), NOP (2)
    vecs[13] = '{1'b0, RTYPE, 1'b1, 4'd1,  C_FETCH_R,  32'd2};
    vecs[14] = '{1'b0, RTYPE, 1'b0, 4'd2,  C_DECODE,   32'd2};
    vecs[15] = '{1'b0, RTYPE, 1'b0, 4'd7,  C_EXECUTE,  32'd2};
    vecs[16] = '{1'b0, RTYPE, 1'b1, 4'd8,  C_ALUWB,    32'd2};
    vecs[17] = '{1'b0, BEQ,   1'b1, 4'd1,  C_FETCH_R,  32'd3};
    vecs[18] = '{1'b0, BEQ,   1'b1, 4'd2,  C_DECODE,   32'd3};
    vecs[19] = '{1'b0, BEQ,   1'b0, 4'd9,  C_BRANCH,   32'd3};
    vecs[20] = '{1'b0, J,     1'b1, 4'd1,  C_FETCH_R,  32'd4};
    vecs[21] = '{1'b0, J,     1'b1, 4'd2,  C_DECODE,   32'd4};
    vecs[22] = '{1'b0, J,     1'b0, 4'd10, C_JUMP,     32'd5 - 32'd1};
    vecs[23] = '{1'b0, NOP,   1'b1, 4'd1,  C_FETCH_R,  32'd5};
    vecs[24] = '{1'b0, NOP,   1'b0, 4'd2,  C_DECODE,   32'd5};
    // Fetch stalled for two cycles, then one IR/PC load pulse
    vecs[25] = '{1'b0, NOP,   1'b0, 4'd1,  C_FETCH_W,  32'd6};
    vecs[26] = '{1'b0, NOP,   1'b0, 4'd1,  C_FETCH_W,  32'd6};
    vecs[27] = '{1'b0, NOP,   1'b1, 4'd1,  C_FETCH_R,  32'd6};
    vecs[28] = '{1'b0, NOP,   1'b1, 4'd2,  C_DECODE,   32'd6};
    // Unrecognised opcode; mem_ready low in DECODE must not matter
    vecs[29] = '{1'b0, BAD,   1'b1, 4'd1,  C_FETCH_R,  32'd7};
    vecs[30] = '{1'b0, BAD,   1'b0, 4'd2,  C_DECODE,   32'd7};

    rst = 1'b1; op_code = NOP; mem_ready = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].op, vecs[i].rdy);
      check_cycle($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].cnt);
    end

    // ILLEGAL absorbs regardless of op_code and mem_ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i % 2 == 0) ? BAD : LW, 1'(i % 2));
      check_cycle($sformatf("illegal%0d", i), 4'd11, C_ILLEGAL, 32'd7);
    end
    step(1'b1, NOP, 1'b1);
    check_cycle("illegal_rst_cyc", 4'd11, C_ILLEGAL, 32'd7);
    step(1'b0, NOP, 1'b1);
    check_cycle("after_illegal_rst", 4'd0, C_IDLE, 32'd0);

    // 16 NOPs: the 4-bit counter passes all-ones and wraps to 0.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, NOP, 1'b1);
      check_cycle($sformatf("nop%0d_fetch", i), 4'd1, C_FETCH_R, 32'(i));
      step(1'b0, NOP, 1'b1);
      check_cycle($sformatf("nop%0d_decode", i), 4'd2, C_DECODE, 32'(i));
    end
    step(1'b0, LW, 1'b0);
    check_cycle("wrap", 4'd1, C_FETCH_W, 32'd16);

    // Reset while MEMREAD waits on memory.
    step(1'b0, LW, 1'b1);
    check_cycle("mr_fetch", 4'd1, C_FETCH_R, 32'd16);
    step(1'b0, LW, 1'b1);
    check_cycle("mr_decode", 4'd2, C_DECODE, 32'd16);
    step(1'b0, LW, 1'b1);
    check_cycle("mr_memaddr", 4'd3, C_MEMADDR, 32'd16);
    step(1'b0, LW, 1'b0);
    check_cycle("mr_wait0", 4'd4, C_MEMREAD, 32'd16);
    step(1'b1, LW, 1'b0);
    check_cycle("mr_wait_rst", 4'd4, C_MEMREAD, 32'd16);
    step(1'b0, LW, 1'b1);
    check_cycle("mr_after_rst", 4'd0, C_IDLE, 32'd0);
    step(1'b0, LW, 1'b1);
    check_cycle("mr_restart", 4'd1, C_FETCH_R, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
